// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IF-stage master on the instruction-memory AR/R channel.
// Keeps one read outstanding, holds the fetch PC, and tracks a branch redirect
// that arrives while a read is in flight.
// Optional build macro IFU_PERF_CNT_EN adds the fetch_count and stall_cycle_count outputs.
module instruction_fetch_unit #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0,
  parameter logic [DATA_SIZE-1:0] NOP_INSTR = DATA_SIZE'(32'h0000_0013)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instruction_stall,
  input  logic                 branch_taken,
  input  logic [ADDR_SIZE-1:0] branch_target,
  input  logic                 im_arready,
  input  logic                 im_rvalid,
  input  logic [DATA_SIZE-1:0] im_rdata,
  output logic                 im_arvalid,
  output logic [ADDR_SIZE-1:0] im_araddr,
  output logic                 im_rready,
  output logic [DATA_SIZE-1:0] instruction,
  output logic [DATA_SIZE-1:0] past_instruction,
  output logic [ADDR_SIZE-1:0] pc_out,
  output logic                 bus_stall
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [31:0]          stall_cycle_count
`endif
);

  typedef enum logic [1:0] {S_ADDR, S_DATA, S_READY} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_SIZE-1:0]   fetch_pc;
  logic [ADDR_SIZE-1:0]   redirect_pc;
  logic                   redirect_pending;
  // Low for the first cycle after reset release so the first request starts on a clock edge.
  logic                   started;
  logic                   data_keep;

  assign im_araddr = fetch_pc;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_ADDR;
    else      state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt  = state;
    im_arvalid = 1'b0;
    im_rready  = 1'b0;
    bus_stall  = 1'b1;
    data_keep  = 1'b0;
    case (state)
      S_ADDR: begin
        im_arvalid = started;
        if (started && im_arready) state_nxt = S_DATA;
      end
      S_DATA: begin
        im_rready = 1'b1;
        if (im_rvalid) begin
          // A redirect seen at any point during this read makes its data stale.
          data_keep = !(redirect_pending || branch_taken);
          state_nxt = data_keep ? S_READY : S_ADDR;
        end
      end
      S_READY: begin
        bus_stall = 1'b0;
        if (branch_taken || !instruction_stall) state_nxt = S_ADDR;
      end
      default: state_nxt = S_ADDR;
    endcase
  end

  // Fetch PC, redirect tracking and instruction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started          <= 1'b0;
      fetch_pc         <= RESET_PC;
      redirect_pc      <= RESET_PC;
      redirect_pending <= 1'b0;
      instruction      <= NOP_INSTR;
      past_instruction <= NOP_INSTR;
      pc_out           <= RESET_PC;
    end else begin
      started <= 1'b1;
      case (state)
        S_ADDR: begin
          // The presented address must stay stable, so the target waits on the side.
          if (branch_taken) begin
            redirect_pc      <= branch_target;
            redirect_pending <= 1'b1;
          end
        end
        S_DATA: begin
          if (im_rvalid) begin
            if (data_keep) begin
              instruction <= im_rdata;
              pc_out      <= fetch_pc;
            end else if (branch_taken) begin
              fetch_pc <= branch_target;
            end else begin
              fetch_pc <= redirect_pc;
            end
            redirect_pending <= 1'b0;
          end else if (branch_taken) begin
            redirect_pc      <= branch_target;
            redirect_pending <= 1'b1;
          end
        end
        S_READY: begin
          if (branch_taken) begin
            fetch_pc         <= branch_target;
            instruction      <= NOP_INSTR;
            past_instruction <= instruction;
          end else if (!instruction_stall) begin
            past_instruction <= instruction;
            fetch_pc         <= fetch_pc + ADDR_SIZE'(4);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters: kept fetches and cycles without a valid instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count       <= '0;
      stall_cycle_count <= '0;
    end else begin
      if (data_keep) fetch_count       <= fetch_count + 32'd1;
      if (bus_stall) stall_cycle_count <= stall_cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: memory responder, address/instruction
// scoreboards, and a directed sequence of fetch, stall, branch and reset scenarios.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        instruction_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        im_arready;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        im_arvalid;
  logic [31:0] im_araddr;
  logic        im_rready;
  logic [31:0] instruction;
  logic [31:0] past_instruction;
  logic [31:0] pc_out;
  logic        bus_stall;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_cycle_count;
  logic [31:0] fc0, sc0;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .instruction_stall (instruction_stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .im_arready        (im_arready),
    .im_rvalid         (im_rvalid),
    .im_rdata          (im_rdata),
    .im_arvalid        (im_arvalid),
    .im_araddr         (im_araddr),
    .im_rready         (im_rready),
    .instruction       (instruction),
    .past_instruction  (past_instruction),
    .pc_out            (pc_out),
    .bus_stall         (bus_stall)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count       (fetch_count),
    .stall_cycle_count (stall_cycle_count)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] past;
  } exp_t;

  exp_t        instr_q[$];
  logic [31:0] addr_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Memory responder controls.
  bit          arready_en = 1'b1;
  int          rd_delay   = 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0010_0093 : (a ^ 32'h5A5A_0013);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] past);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.past  = past;
    instr_q.push_back(e);
  endtask

  // Called at a negedge; returns at the first negedge where bus_stall is low.
  task automatic wait_ready();
    int n;
    n = 0;
    while (bus_stall !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("ready_timeout", 32'd1, 32'd0);
  endtask

  // Called at a negedge in the ready state; advances once and waits for the next instruction.
  task automatic step();
    instruction_stall = 1'b0;
    @(negedge clk);
    instruction_stall = 1'b1;
    wait_ready();
  endtask

  // Memory: accepts one address, returns data rd_delay cycles after the handshake.
  initial begin
    bit          hs, bt, busy;
    logic [31:0] hs_addr, raddr;
    int          cnt;
    busy = 1'b0; cnt = 0; raddr = '0;
    im_arready = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
    forever begin
      @(negedge clk);
      hs      = im_arvalid && im_arready;
      hs_addr = im_araddr;
      bt      = im_rvalid && im_rready;
      @(posedge clk);
      #1;
      if (bt) begin
        im_rvalid = 1'b0;
        busy      = 1'b0;
      end
      if (hs) begin
        busy  = 1'b1;
        raddr = hs_addr;
        cnt   = rd_delay;
      end
      if (busy && !im_rvalid) begin
        if (cnt <= 1) begin
          im_rvalid = 1'b1;
          im_rdata  = mem(raddr);
        end else begin
          cnt--;
        end
      end
      if (!rst) begin
        busy      = 1'b0;
        im_rvalid = 1'b0;
      end
      im_arready = arready_en;
    end
  end

  // Monitor: checks every presented address and every newly valid instruction.
  initial begin
    logic prev_stall;
    exp_t e;
    prev_stall = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (im_arvalid) begin
          if (addr_q.size() == 0) begin
            chk("araddr_unexpected", im_araddr, 32'hFFFF_FFFF);
          end else begin
            chk("araddr", im_araddr, addr_q[0]);
            if (im_arready) void'(addr_q.pop_front());
          end
        end
        if (prev_stall && !bus_stall) begin
          if (instr_q.size() == 0) begin
            chk("instr_unexpected", instruction, 32'hFFFF_FFFF);
          end else begin
            e = instr_q.pop_front();
            chk("instruction", instruction, e.instr);
            chk("pc_out", pc_out, e.pc);
            chk("past_instruction", past_instruction, e.past);
          end
        end
      end
      prev_stall = bus_stall;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    instruction_stall = 1'b1;
    branch_taken = 1'b0;
    branch_target = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_arvalid", im_arvalid, 0);
    chk("rst_rready", im_rready, 0);
    chk("rst_instruction", instruction, NOP);
    chk("rst_past", past_instruction, NOP);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_bus_stall", bus_stall, 1);

    // First fetch after release: arvalid on first edge, instruction two cycles later
    addr_q.push_back(32'h0);
    push_exp(32'h0, 32'h0010_0093, NOP);
    rst = 1'b1;
    #1 chk("arvalid_before_edge", im_arvalid, 0);
    @(negedge clk);
    chk("first_arvalid", im_arvalid, 1);
    @(negedge clk);
    chk("first_bus_stall_data", bus_stall, 1);
    @(negedge clk);
    chk("first_bus_stall_ready", bus_stall, 0);

    // Free-running sequential fetch 0 -> 4 -> 8
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    push_exp(32'h4, mem(32'h4), 32'h0010_0093);
    push_exp(32'h8, mem(32'h8), mem(32'h4));
    instruction_stall = 1'b0;
    repeat (2) begin
      @(negedge clk);
      wait_ready();
    end
    instruction_stall = 1'b1;

    // Decode hold for 5 cycles
    repeat (5) begin
      @(negedge clk);
      chk("hold_arvalid", im_arvalid, 0);
      chk("hold_instruction", instruction, mem(32'h8));
      chk("hold_pc_out", pc_out, 32'h8);
      chk("hold_past", past_instruction, mem(32'h4));
    end
    addr_q.push_back(32'hC);
    push_exp(32'hC, mem(32'hC), mem(32'h8));
    step();

    // Redirect while the read is outstanding; returned data is discarded
    rd_delay = 3;
    addr_q.push_back(32'h10);
    addr_q.push_back(32'h100);
    push_exp(32'h100, mem(32'h100), mem(32'hC));
`ifdef IFU_PERF_CNT_EN
    fc0 = fetch_count;
`endif
    instruction_stall = 1'b0;
    @(negedge clk);
    instruction_stall = 1'b1;
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("redirect_bus_stall", bus_stall, 1);
    wait_ready();
    rd_delay = 1;
`ifdef IFU_PERF_CNT_EN
    chk("fetch_count_discard", fetch_count - fc0, 32'd1);
`endif

    // arready held low, then reset asserted during the wait
    arready_en = 1'b0;
    addr_q.push_back(32'h104);
    instruction_stall = 1'b0;
    @(negedge clk);
    instruction_stall = 1'b1;
    repeat (4) begin
      chk("arwait_bus_stall", bus_stall, 1);
      chk("arwait_arvalid", im_arvalid, 1);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_arvalid", im_arvalid, 0);
    chk("midrst_instruction", instruction, NOP);
    chk("midrst_past", past_instruction, NOP);
    chk("midrst_pc_out", pc_out, 0);
    chk("midrst_bus_stall", bus_stall, 1);
    addr_q.delete();
    instr_q.delete();
    @(negedge clk);
    arready_en = 1'b1;
    addr_q.push_back(32'h0);
    push_exp(32'h0, 32'h0010_0093, NOP);
    rst = 1'b1;
    @(negedge clk);
    wait_ready();

    // Branch in ready state wins over a held stall; then PC wraps
`ifdef IFU_PERF_CNT_EN
    fc0 = fetch_count;
`endif
    addr_q.push_back(32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 32'h0010_0093);
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("branch_nop", instruction, NOP);
    chk("branch_past", past_instruction, 32'h0010_0093);
    wait_ready();
    addr_q.push_back(32'h0);
    push_exp(32'h0, 32'h0010_0093, mem(32'hFFFF_FFFC));
`ifdef IFU_PERF_CNT_EN
    sc0 = stall_cycle_count;
`endif
    step();
`ifdef IFU_PERF_CNT_EN
    chk("fetch_count_wrap", fetch_count - fc0, 32'd2);
    chk("stall_cycle_step", stall_cycle_count - sc0, 32'd2);
`endif

    repeat (3) @(negedge clk);
    chk("addr_q_drained", addr_q.size(), 0);
    chk("instr_q_drained", instr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
